shifter_operand_stage: RTL and testbench

Pipeline stage directly upstream of the barrel shifter.
- Decodes the operand-2 field of an ARMv7 data-processing instruction, together with the Rm and Rs register values and the CPSR C flag, into the shifter's control inputs: SHFT_OP, Shift_Data, Shift_Num, Carry_flag.
- Registered output with a valid/ready handshake and a 2-entry skid buffer.
- A flush input supports branch/exception squash.

---
 rtl/shifter_pkg.sv | 40 ++++
 rtl/shifter_operand_stage_operand2_decode.sv | 57 +++++
 rtl/shifter_operand_stage.sv | 111 +++++++++++
 tb/tb_shifter_operand_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared shifter definitions: SHFT_OP codes, shift-type field, and the decoded
// operand-2 control bundle consumed by the barrel shifter.
package shifter_pkg;

  localparam int SHFT_DATA_W = 32;
  localparam int SHFT_NUM_W  = 8;

  localparam logic [2:0] SHFT_LSL     = 3'b000;
  localparam logic [2:0] SHFT_LSR     = 3'b001;
  localparam logic [2:0] SHFT_ASR     = 3'b010;
  localparam logic [2:0] SHFT_ROR     = 3'b011;
  localparam logic [2:0] SHFT_IMM_ROR = 3'b100;
  localparam logic [2:0] SHFT_RRX     = 3'b110;
  localparam logic [2:0] SHFT_PASS    = 3'b111;

  typedef enum logic [1:0] {
    SHIFT_TYPE_LSL = 2'b00,
    SHIFT_TYPE_LSR = 2'b01,
    SHIFT_TYPE_ASR = 2'b10,
    SHIFT_TYPE_ROR = 2'b11
  } shift_type_e;

  typedef struct packed {
    logic [2:0]             shft_op;
    logic [SHFT_DATA_W-1:0] shift_data;
    logic [SHFT_NUM_W-1:0]  shift_num;
    logic                   carry_flag;
    logic                   illegal;
  } shft_ctrl_t;

  function automatic logic [2:0] type_to_op(input shift_type_e t);
    case (t)
      SHIFT_TYPE_LSL: type_to_op = SHFT_LSL;
      SHIFT_TYPE_LSR: type_to_op = SHFT_LSR;
      SHIFT_TYPE_ASR: type_to_op = SHFT_ASR;
      default:        type_to_op = SHFT_ROR;
    endcase
  endfunction

endpackage

// File: rtl/shifter_operand_stage_operand2_decode.sv
// Combinational decode of an ARM data-processing operand-2 field plus Rm/Rs/C
// into the barrel shifter control bundle.
module operand2_decode
  import shifter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_W  = 8
) (
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rm_data,
  input  logic [DATA_W-1:0] rs_data,
  input  logic              carry,
  output shft_ctrl_t        ctrl
);

  shift_type_e stype;
  logic [4:0]  imm5;
  logic        unused_bits;

  assign stype       = shift_type_e'(instr[6:5]);
  assign imm5        = instr[11:7];
  assign unused_bits = ^{instr[31:26], instr[24:12], rs_data[DATA_W-1:NUM_W]};

  always_comb begin
    ctrl            = '0;
    ctrl.carry_flag = carry;
    ctrl.shift_data = rm_data;
    if (instr[25]) begin
      ctrl.shft_op    = SHFT_IMM_ROR;
      ctrl.shift_data = {24'b0, instr[7:0]};
      ctrl.shift_num  = {3'b0, instr[11:8], 1'b0};
    end else if (!instr[4]) begin
      // Immediate shift: amount 0 re-encodes LSR/ASR #32, RRX and plain pass
      ctrl.shft_op   = type_to_op(stype);
      ctrl.shift_num = {3'b0, imm5};
      if (imm5 == 5'd0) begin
        case (stype)
          SHIFT_TYPE_LSL: ctrl.shft_op = SHFT_PASS;
          SHIFT_TYPE_LSR,
          SHIFT_TYPE_ASR: ctrl.shift_num = 8'd32;
          default: begin
            ctrl.shft_op   = SHFT_RRX;
            ctrl.shift_num = 8'd1;
          end
        endcase
      end
    end else if (instr[7]) begin
      ctrl.shft_op   = SHFT_PASS;
      ctrl.shift_num = '0;
      ctrl.illegal   = 1'b1;
    end else begin
      ctrl.shft_op   = type_to_op(stype);
      ctrl.shift_num = rs_data[NUM_W-1:0];
    end
  end

endmodule

// File: rtl/shifter_operand_stage.sv
// Operand-2 decode stage ahead of the barrel shifter: registered output with a
// 2-entry skid buffer and flush. Optional counters under SHIFTER_OPSTAGE_PERF_EN.
module shifter_operand_stage
  import shifter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rm_data,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        SHFT_OP,
  output logic [DATA_W-1:0] Shift_Data,
  output logic [NUM_W-1:0]  Shift_Num,
  output logic              Carry_flag,
  output logic              out_illegal
`ifdef SHIFTER_OPSTAGE_PERF_EN
  ,
  output logic [15:0]       perf_issued,
  output logic [15:0]       perf_stall
`endif
);

  shft_ctrl_t dec_p0;
  shft_ctrl_t out_p1;
  shft_ctrl_t skid_p1;
  logic       vld_p1;
  logic       skid_vld_p1;
  logic       in_ready_q;
  logic       accept;
  logic       xfer;

  operand2_decode #(
    .DATA_W(DATA_W),
    .NUM_W (NUM_W)
  ) u_decode (
    .instr  (in_instr),
    .rm_data(in_rm_data),
    .rs_data(in_rs_data),
    .carry  (in_carry),
    .ctrl   (dec_p0)
  );

  assign accept = in_valid && in_ready_q;
  assign xfer   = vld_p1 && out_ready;

  // p0 -> p1: output register holds the oldest entry, skid holds the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready_q  <= 1'b1;
      out_p1      <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (!vld_p1 || xfer) begin
      // in_ready is low whenever the skid is occupied, so no accept here
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= accept;
        if (accept) out_p1 <= dec_p0;
      end
      in_ready_q <= 1'b1;
    end else if (accept) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
      in_ready_q  <= 1'b0;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = vld_p1;
  assign SHFT_OP     = out_p1.shft_op;
  assign Shift_Data  = out_p1.shift_data;
  assign Shift_Num   = out_p1.shift_num;
  assign Carry_flag  = out_p1.carry_flag;
  assign out_illegal = out_p1.illegal;

`ifdef SHIFTER_OPSTAGE_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && v != 16'hFFFF) sat_inc = v + 16'd1;
    else                     sat_inc = v;
  endfunction

  // Counters survive flush; only reset clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      perf_issued <= sat_inc(perf_issued, xfer);
      perf_stall  <= sat_inc(perf_stall, vld_p1 && !out_ready);
    end
  end
`endif

endmodule

// File: tb/tb_shifter_operand_stage.sv
// Scoreboard bench for shifter_operand_stage: accepted entries are modelled and
// queued, and every valid output is compared against the queue head.
module tb_shifter_operand_stage;

  typedef logic [44:0] exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rm_data;
  logic [31:0] in_rs_data;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  SHFT_OP;
  logic [31:0] Shift_Data;
  logic [7:0]  Shift_Num;
  logic        Carry_flag;
  logic        out_illegal;
`ifdef SHIFTER_OPSTAGE_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_stall;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  shifter_operand_stage #(.DATA_W(32), .NUM_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rm_data (in_rm_data),
    .in_rs_data (in_rs_data),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .SHFT_OP    (SHFT_OP),
    .Shift_Data (Shift_Data),
    .Shift_Num  (Shift_Num),
    .Carry_flag (Carry_flag),
    .out_illegal(out_illegal)
`ifdef SHIFTER_OPSTAGE_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall (perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] rm,
                                 input logic [31:0] rs, input logic c);
    logic [2:0]  op;
    logic [31:0] data;
    logic [7:0]  num;
    logic        ill;
    logic [4:0]  amt;
    amt  = instr[11:7];
    data = rm;
    ill  = 1'b0;
    if (instr[25]) begin
      op   = 3'd4;
      data = {24'd0, instr[7:0]};
      num  = 8'(instr[11:8]) * 8'd2;
    end else if (instr[4] && instr[7]) begin
      op  = 3'd7;
      num = 8'd0;
      ill = 1'b1;
    end else if (instr[4]) begin
      op  = {1'b0, instr[6:5]};
      num = rs[7:0];
    end else begin
      case (instr[6:5])
        2'd0: begin op = (amt == 0) ? 3'd7 : 3'd0; num = 8'(amt); end
        2'd1: begin op = 3'd1; num = (amt == 0) ? 8'd32 : 8'(amt); end
        2'd2: begin op = 3'd2; num = (amt == 0) ? 8'd32 : 8'(amt); end
        default: begin op = (amt == 0) ? 3'd6 : 3'd3; num = (amt == 0) ? 8'd1 : 8'(amt); end
      endcase
    end
    return {op, data, num, c, ill};
  endfunction

  // Called at a falling edge after inputs are set; returns at the next falling edge
  task automatic cycle();
    #1;
    if (out_valid) begin
      if (q.size() == 0) check("spurious_out_valid", 64'(out_valid), 64'd0);
      else check("out_head", 64'({SHFT_OP, Shift_Data, Shift_Num, Carry_flag, out_illegal}), 64'(q[0]));
    end
    if (flush) q.delete();
    else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(in_instr, in_rm_data, in_rs_data, in_carry));
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] rm,
                      input logic [31:0] rs, input logic c);
    in_valid = 1'b1;
    in_instr = instr;
    in_rm_data = rm;
    in_rs_data = rs;
    in_carry = c;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic fill_stalled();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hE1A00000;
    for (int i = 0; i < 5 && in_ready; i++) begin
      in_rm_data = 32'h100 + 32'(i);
      cycle();
    end
    check("fill_in_ready_low", 64'(in_ready), 64'd0);
  endtask

  initial begin
    logic [31:0] tag;
    int          acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_rm_data = '0; in_rs_data = '0; in_carry = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'({SHFT_OP, Shift_Data, Shift_Num, Carry_flag, out_illegal}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    send(32'hE3A004FF, 32'h12345678, 32'h0, 1'b1);
    check("imm_latency", 64'(out_valid), 64'd1);
    check("imm_op", 64'(SHFT_OP), 64'd4);
    check("imm_data", 64'(Shift_Data), 64'hFF);
    check("imm_num", 64'(Shift_Num), 64'd8);
    check("imm_carry", 64'(Carry_flag), 64'd1);
    cycle();

    send(32'hE1A00020, 32'hAAAAFF00, 32'h0, 1'b0);
    check("lsr0_op", 64'(SHFT_OP), 64'd1);
    check("lsr0_num", 64'(Shift_Num), 64'd32);
    check("lsr0_data", 64'(Shift_Data), 64'hAAAAFF00);
    cycle();

    send(32'hE1A00060, 32'h87654321, 32'h0, 1'b0);
    check("rrx_op", 64'(SHFT_OP), 64'd6);
    check("rrx_num", 64'(Shift_Num), 64'd1);
    check("rrx_carry0", 64'(Carry_flag), 64'd0);
    cycle();
    send(32'hE1A00060, 32'h87654321, 32'h0, 1'b1);
    check("rrx_carry1", 64'(Carry_flag), 64'd1);
    cycle();

    send(32'hE1A00312, 32'h0000F0F0, 32'h00000140, 1'b0);
    check("reg_op", 64'(SHFT_OP), 64'd0);
    check("reg_num", 64'(Shift_Num), 64'h40);
    check("reg_illegal", 64'(out_illegal), 64'd0);
    cycle();
    send(32'hE1A00392, 32'h0000F0F0, 32'h00000140, 1'b0);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_op", 64'(SHFT_OP), 64'd7);
    check("ill_num", 64'(Shift_Num), 64'd0);
    cycle();

    // Backpressure with tagged Rm values
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hE1A00000;
    tag = 32'd1; acc = 0;
    for (int i = 0; i < 3; i++) begin
      in_rm_data = tag;
      if (in_ready) begin acc++; tag++; end
      cycle();
    end
    check("bp_accepted", 64'(acc), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_stable_valid", 64'(out_valid), 64'd1);
    check("bp_head_tag", 64'(Shift_Data), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && tag <= 32'd6; i++) begin
      in_rm_data = tag;
      if (in_ready) tag++;
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
    check("bp_drained", 64'(q.size()), 64'd0);

    // Flush with both entries full and a new input presented
    fill_stalled();
    flush = 1'b1; in_valid = 1'b1; in_rm_data = 32'hDEAD;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset mid-stall
    fill_stalled();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_data", 64'(Shift_Data), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) cycle();

    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 29) == 0);
      in_instr   = $urandom;
      in_instr[27:26] = 2'b00;
      in_rm_data = $urandom;
      in_rs_data = $urandom;
      in_carry   = 1'($urandom_range(0, 1));
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
    check("final_drained", 64'(q.size()), 64'd0);
    check("final_out_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
